// File: rtl/sonic_echo_emu.sv
// sonic_echo_emu
// Emulates an ultrasonic ranging sensor (HC-SR04 style). A trigger pulse of at
// least TRIG_MIN_CYC synchronized cycles is accepted when it falls. After a
// fixed burst delay, echo is held high for a time proportional to the object
// distance. Out-of-range distances produce a no-object timeout pulse instead.
//
// Ports
//   clk          in   system clock, the only clock
//   rst          in   asynchronous active-high reset
//   trig         in   trigger from the sensor controller, asynchronous to clk
//   distance_cm  in   emulated object distance in cm (unsigned, 9 bits)
//   echo         out  emulated echo pulse (flop output)
//   busy         out  high from trigger acceptance until echo falls (flop output)
//   dbg_state    out  current FSM state, for observation only
//
// There is no handshake: trig is a level-sampled pulse, and echo/busy are
// free-running status levels with no back-pressure.

module sonic_echo_emu #(
  parameter int unsigned TRIG_MIN_CYC = 1000,
  parameter int unsigned BURST_CYC    = 20000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_CYC  = 3800000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // The 22-bit phase counter and length arithmetic cover both the largest
  // in-range echo (400 * 5800 = 2320000) and the 3800000 timeout.
  localparam int CW = 22;

  localparam logic [CW-1:0] TRIG_MIN_W   = CW'(TRIG_MIN_CYC);
  localparam logic [CW-1:0] BURST_W      = CW'(BURST_CYC);
  localparam logic [CW-1:0] CYC_PER_CM_W = CW'(CYC_PER_CM);
  localparam logic [CW-1:0] TIMEOUT_W    = CW'(TIMEOUT_CYC);
  localparam logic [8:0]    MAX_CM_W     = 9'(MAX_CM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRIG_HI = 2'd1,
    BURST   = 2'd2,
    ECHO    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          trig_meta_q;
  logic          trig_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    dist_q, dist_d;
  logic          echo_q, echo_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] echo_len;

  // Two-flop synchronizer for the asynchronous trigger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
    end else begin
      trig_meta_q <= trig;
      trig_s_q    <= trig_meta_q;
    end
  end

  // Echo length derived from the distance latched at acceptance, so later
  // changes on distance_cm cannot disturb an echo in progress.
  always_comb begin
    echo_len = TIMEOUT_W;
    if ((dist_q != 9'd0) && (dist_q <= MAX_CM_W)) begin
      echo_len = CW'(dist_q) * CYC_PER_CM_W;
    end
  end

  // Next-state logic. cnt_q is shared: trig width in TRIG_HI, elapsed burst
  // cycles in BURST, elapsed echo cycles in ECHO (all counting from 1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    echo_d  = echo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (trig_s_q) begin
          state_d = TRIG_HI;
          cnt_d   = CW'(1);
        end
      end
      TRIG_HI: begin
        if (trig_s_q) begin
          if (cnt_q < TRIG_MIN_W) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q >= TRIG_MIN_W) begin
          dist_d  = distance_cm;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
          state_d = BURST;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      BURST: begin
        // Echo rises on the edge that closes the last burst cycle.
        if (cnt_q == BURST_W) begin
          echo_d  = 1'b1;
          cnt_d   = CW'(1);
          state_d = ECHO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ECHO: begin
        if (cnt_q == echo_len) begin
          echo_d  = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        echo_d  = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dist_q  <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
    end
  end

  assign echo      = echo_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: doc/sonic_echo_emu.md
SONIC_ECHO_EMU -- requirements
Module: sonic_echo_emu

Interface
REQ-001 Parameter TRIG_MIN_CYC, default 1000; minimum synchronized trig high width in clk cycles (10 us at 100 MHz).
REQ-002 Parameter BURST_CYC, default 20000; delay in clk cycles from accepted trig fall to echo rise (200 us).
REQ-003 Parameter CYC_PER_CM, default 5800; echo high cycles per cm (58 us/cm).
REQ-004 Parameter MAX_CM, default 400; largest distance that produces a normal echo.
REQ-005 Parameter TIMEOUT_CYC, default 3800000; echo high cycles for a no-object return (38 ms).
REQ-006 clk  input  1  system clock, 100 MHz; the block's only clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 trig  input  1  trigger pulse from the sensor controller; asynchronous to clk.
REQ-009 distance_cm  input  9  emulated object distance in cm; unsigned.
REQ-010 echo  output  1  emulated sensor echo pulse; registered.
REQ-011 busy  output  1  high from trig acceptance until echo falls; registered.

Function
REQ-012 trig SHALL pass through a 2-flop synchronizer; trig_s is the second flop's output, and all trig timing below refers to trig_s.
REQ-013 The FSM SHALL have 4 states: IDLE, TRIG_HI, BURST, ECHO.
REQ-014 IDLE: on trig_s = 1, go to TRIG_HI with the width counter set to 1.
REQ-015 TRIG_HI: while trig_s = 1, increment the width counter, saturating at TRIG_MIN_CYC.
REQ-016 TRIG_HI on trig_s = 0 with width >= TRIG_MIN_CYC: latch distance_cm, load the echo length, set busy = 1, go to BURST.
REQ-017 TRIG_HI on trig_s = 0 with width < TRIG_MIN_CYC: return to IDLE; no echo, busy stays 0.
REQ-018 Echo length SHALL be distance_cm * CYC_PER_CM when 1 <= distance_cm <= MAX_CM; otherwise, including 0 and 401..511, it SHALL be TIMEOUT_CYC.
REQ-019 Echo-length arithmetic and the phase counter SHALL be 22-bit unsigned (max 2320000 and 3800000 both fit); no truncation is allowed.
REQ-020 BURST SHALL last exactly BURST_CYC cycles; echo SHALL rise on the clk edge ending the last BURST cycle.
REQ-021 ECHO: echo = 1 for exactly the loaded echo length in clk cycles; on the final cycle go to IDLE, and echo and busy fall on the same edge.
REQ-022 trig_s activity in BURST or ECHO SHALL be ignored; a trig still high on return to IDLE SHALL start TRIG_HI measurement from that cycle.
REQ-023 distance_cm changes after latching SHALL NOT affect the echo in progress.
REQ-024 echo and busy SHALL be driven directly from flops, with no combinational path from trig or distance_cm.
REQ-025 End-to-end latency SHALL be deterministic: echo rise = trig fall at pin + 2 (synchronizer) + 1 (FSM) + BURST_CYC cycles, with +/-1 cycle allowed only for the asynchronous trig sampling.

Reset
REQ-026 While rst = 1: state IDLE, echo = 0, busy = 0, all counters, latched distance and synchronizer flops 0.
REQ-027 rst asserted mid-BURST or mid-ECHO SHALL drop echo and busy immediately (asynchronously).
REQ-028 After rst falls, the block SHALL need a fresh trig of at least TRIG_MIN_CYC; a trig already high during reset counts width only from the first post-reset trig_s = 1 cycle.

Verification
REQ-029 trig high 1000 cycles, distance_cm = 10 -> echo rises 20000 (+3) cycles after trig fall and stays high exactly 58000 cycles; busy spans the same window plus the BURST phase.
REQ-030 trig high 999 cycles -> no echo, busy stays 0; a following 1000-cycle trig produces a normal echo.
REQ-031 distance_cm = 0, then 401, then 400 -> echo widths 3800000, 3800000, 2320000 cycles.
REQ-032 Second trig issued during ECHO, and distance_cm changed during ECHO -> no width change, no retrigger; one echo only.
REQ-033 rst pulsed 1000 cycles into ECHO -> echo and busy go to 0 immediately; no echo until the next valid trig.
REQ-034 Back-to-back valid trigs spaced 10000000 cycles apart, distance_cm = 40 -> every echo is exactly 232000 cycles and every busy window is identical.
